mult_div_unit: RTL



---
 rtl/mult_div_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO, plus MTHI/MTLO writes.
// Latency: start edge E0, WIDTH iterations in CALC, sign fix-up in FIX, done_o pulse in DONE.
// Optional flush port abort_i is enabled by defining MDU_ABORT_EN.
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] RSdata_i,
   input  logic [WIDTH-1:0] RTdata_i,
   input  logic             mthi_i,
   input  logic             mtlo_i,
`ifdef MDU_ABORT_EN
   input  logic             abort_i,
`endif
   output logic             busy_o,
   output logic             done_o,
   output logic             div_zero_o,
   output logic [WIDTH-1:0] HI_o,
   output logic [WIDTH-1:0] LO_o
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t             state, state_nxt;
   logic               abort;
   logic               is_div_q;
   logic               sign_a_q, sign_b_q;
   logic               dz_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [2*WIDTH-1:0] acc_q;

`ifdef MDU_ABORT_EN
   assign abort = abort_i;
`else
   assign abort = 1'b0;
`endif

   // Launch decode: signed ops work on magnitudes and remember the operand signs
   logic             accept, op_signed, start_dz, in_sign_a, in_sign_b, last_iter;
   logic [WIDTH-1:0] abs_a, abs_b;

   assign accept    = (state == S_IDLE) && start_i && !abort;
   assign op_signed = ~op_i[0];
   assign start_dz  = op_i[1] && (RTdata_i == '0);
   assign in_sign_a = op_signed && RSdata_i[WIDTH-1];
   assign in_sign_b = op_signed && RTdata_i[WIDTH-1];
   assign abs_a     = in_sign_a ? (~RSdata_i + 1'b1) : RSdata_i;
   assign abs_b     = in_sign_b ? (~RTdata_i + 1'b1) : RTdata_i;
   assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; abort only flushes work in progress, never a pending DONE
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = start_dz ? S_DONE : S_CALC;
         S_CALC: begin
            if (abort)          state_nxt = S_IDLE;
            else if (last_iter) state_nxt = S_FIX;
         end
         S_FIX:  state_nxt = abort ? S_IDLE : S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Status outputs decoded from the state
   always_comb begin
      busy_o     = (state == S_CALC) || (state == S_FIX);
      done_o     = (state == S_DONE);
      div_zero_o = (state == S_DONE) && dz_q;
   end

   // One iteration step: shift-add multiply (multiplier in low half) or
   // restoring divide (remainder high half, dividend/quotient low half)
   logic [WIDTH:0]     mul_sum, rem_sh, diff;
   logic [2*WIDTH-1:0] mul_nxt, div_nxt;
   always_comb begin
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
      mul_nxt = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
      rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      diff    = rem_sh - {1'b0, opnd_q};
      div_nxt = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                            : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};
   end

   // Iteration datapath: both operations load the same way, only the step differs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         is_div_q <= 1'b0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         dz_q     <= 1'b0;
         cnt_q    <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
      end else if (accept) begin
         is_div_q <= op_i[1];
         sign_a_q <= in_sign_a;
         sign_b_q <= in_sign_b;
         dz_q     <= start_dz;
         cnt_q    <= '0;
         opnd_q   <= abs_b;
         acc_q    <= {{WIDTH{1'b0}}, abs_a};
      end else if (state == S_CALC) begin
         cnt_q <= cnt_q + 1'b1;
         acc_q <= is_div_q ? div_nxt : mul_nxt;
      end
   end

   // Sign fix-up of the unsigned result; sign flags are zero for unsigned ops
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   always_comb begin
      prod_fix = (sign_a_q ^ sign_b_q) ? (~acc_q + 1'b1) : acc_q;
      quo_fix  = (sign_a_q ^ sign_b_q) ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
      rem_fix  = sign_a_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
   end

   // Architectural HI/LO: written only by a completed FIX or an IDLE move
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         HI_o <= '0;
         LO_o <= '0;
      end else if (state == S_FIX && !abort) begin
         if (is_div_q) begin
            HI_o <= rem_fix;
            LO_o <= quo_fix;
         end else begin
            HI_o <= prod_fix[2*WIDTH-1:WIDTH];
            LO_o <= prod_fix[WIDTH-1:0];
         end
      end else if (state == S_IDLE && !start_i) begin
         if (mthi_i) HI_o <= RSdata_i;
         if (mtlo_i) LO_o <= RSdata_i;
      end
   end

endmodule
